// File: rtl/scope_trig_reader.sv
// rtl/scope_trig_reader.sv - triggered frame capture from a FIFO read port into a skid-buffered sample stream
module scope_trig_reader #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_LEN    = 1024,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_empty,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_edge,
    input  logic                  trig_auto,
    output logic [DATA_WIDTH-1:0] smp_data,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic                  smp_last,
    output logic                  busy,
    output logic                  trig_forced
);

    localparam logic [11:0] FRAME_LEN_W  = 12'(FRAME_LEN);
    localparam logic [10:0] LAST_IDX     = 11'(FRAME_LEN - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(AUTO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  in_flight;
    logic [DATA_WIDTH-1:0] prev_sample;
    logic                  prev_valid;
    logic [15:0]           timeout_cnt;
    logic [10:0]           read_cnt;
    logic [10:0]           out_cnt;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] tail_data;
    logic                  tail_valid;

    logic       pop;
    logic       trig_hit;
    logic       timeout_hit;
    logic [1:0] occ;
    logic [1:0] occ_after;
    logic       room;
    logic       below_len;
    logic       frame_done;

    // A returned sample arrives exactly one cycle after the read that fetched it
    assign pop         = head_valid && smp_ready;
    assign trig_hit    = in_flight && prev_valid &&
                         (trig_edge ? ((prev_sample > trig_level) && (rd_data <= trig_level))
                                    : ((prev_sample < trig_level) && (rd_data >= trig_level)));
    assign timeout_hit = trig_auto && (timeout_cnt == TIMEOUT_LAST);

    // Room is judged after this cycle's pop so a full-rate stream keeps one read per cycle
    assign occ        = {1'b0, head_valid} + {1'b0, tail_valid};
    assign occ_after  = occ - {1'b0, pop};
    assign room       = (occ_after + {1'b0, in_flight}) < 2'd2;
    // Counting the in-flight read keeps the total fetched per frame at FRAME_LEN
    assign below_len  = ({1'b0, read_cnt} + {11'd0, in_flight}) < FRAME_LEN_W;
    assign frame_done = pop && smp_last;

    assign smp_data    = head_data;
    assign smp_valid   = head_valid;
    assign smp_last    = head_valid && (out_cnt == LAST_IDX);
    assign busy        = (state != IDLE);

    // State register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and read request; abort outranks arm and trigger
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (arm && !abort) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                rd_en = !rd_empty;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (trig_hit || timeout_hit) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                rd_en = !rd_empty && room && below_len;
                if (abort || frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rd_rst || abort) begin
            rd_en = 1'b0;
        end
    end

    // Datapath: trigger history, counters, skid buffer and forced-trigger flag
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            in_flight   <= 1'b0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            timeout_cnt <= '0;
            read_cnt    <= '0;
            out_cnt     <= '0;
            head_data   <= '0;
            head_valid  <= 1'b0;
            tail_data   <= '0;
            tail_valid  <= 1'b0;
            trig_forced <= 1'b0;
        end else begin
            in_flight <= rd_en;
            if (abort) begin
                // Data returning this cycle is simply not captured
                prev_valid  <= 1'b0;
                timeout_cnt <= '0;
                read_cnt    <= '0;
                out_cnt     <= '0;
                head_data   <= '0;
                head_valid  <= 1'b0;
                tail_data   <= '0;
                tail_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            trig_forced <= 1'b0;
                            timeout_cnt <= '0;
                            prev_valid  <= 1'b0;
                            read_cnt    <= '0;
                            out_cnt     <= '0;
                        end
                    end
                    ARMED: begin
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        if (in_flight) begin
                            prev_sample <= rd_data;
                            prev_valid  <= 1'b1;
                        end
                        if (trig_hit) begin
                            head_data  <= rd_data;
                            head_valid <= 1'b1;
                            read_cnt   <= 11'd1;
                        end else if (timeout_hit) begin
                            trig_forced <= 1'b1;
                            read_cnt    <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (in_flight) begin
                            read_cnt <= read_cnt + 11'd1;
                        end
                        if (frame_done) begin
                            out_cnt <= '0;
                        end else if (pop) begin
                            out_cnt <= out_cnt + 11'd1;
                        end
                        if (pop) begin
                            if (tail_valid) begin
                                head_data  <= tail_data;
                                head_valid <= 1'b1;
                                if (in_flight) begin
                                    tail_data <= rd_data;
                                end else begin
                                    tail_valid <= 1'b0;
                                end
                            end else if (in_flight) begin
                                head_data  <= rd_data;
                                head_valid <= 1'b1;
                            end else begin
                                head_valid <= 1'b0;
                            end
                        end else if (in_flight) begin
                            if (head_valid) begin
                                tail_data  <= rd_data;
                                tail_valid <= 1'b1;
                            end else begin
                                head_data  <= rd_data;
                                head_valid <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        head_valid <= 1'b0;
                        tail_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
